// File: rtl/aes_stream_sched.sv
// Packet-granular round-robin scheduler feeding a fixed-latency AES pipeline from two AXI-Stream
// sources, with channel/last tags delayed to meet the core output and credit-gated tready.
module aes_stream_sched #(
   parameter int C_DATA_WIDTH = 128,
   parameter int C_PIPE_LAT   = 30,
   parameter int C_FIFO_DEPTH = 256,
   parameter int C_CRED_WIDTH = 9
) (
   input  logic                      m_axi_mm2s_aclk,
   input  logic                      axi_resetn,
   input  logic [C_DATA_WIDTH-1:0]   s0_tdata,
   input  logic                      s0_tvalid,
   input  logic                      s0_tlast,
   output logic                      s0_tready,
   input  logic [C_DATA_WIDTH-1:0]   s1_tdata,
   input  logic                      s1_tvalid,
   input  logic                      s1_tlast,
   output logic                      s1_tready,
   output logic [C_DATA_WIDTH-1:0]   aes_din,
   output logic                      aes_din_vld,
   input  logic [C_DATA_WIDTH-1:0]   aes_dout,
   output logic                      fifo_wr_en,
   output logic [C_DATA_WIDTH+1:0]   fifo_din,
   input  logic                      fifo_rd_en,
   output logic                      grant_ch,
   output logic                      busy,
   output logic [1:0]                pkt_done
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   localparam logic [C_CRED_WIDTH-1:0] CRED_MAX = C_CRED_WIDTH'(C_FIFO_DEPTH);
   localparam logic [C_CRED_WIDTH-1:0] CRED_ONE = C_CRED_WIDTH'(1);

   state_t                    state, state_nxt;
   logic                      rr_ptr, rr_ptr_nxt;
   logic                      grant_q, grant_nxt;
   logic [C_CRED_WIDTH-1:0]   credits;
   logic                      accept, acc_last;
   logic [C_DATA_WIDTH-1:0]   acc_data;

   // Stage 0 lines up with aes_din; stage C_PIPE_LAT lines up with aes_dout.
   logic [C_PIPE_LAT:0]       tag_vld, tag_last, tag_ch;

   always_ff @(posedge m_axi_mm2s_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state   <= IDLE;
         rr_ptr  <= 1'b0;
         grant_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         rr_ptr  <= rr_ptr_nxt;
         grant_q <= grant_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      rr_ptr_nxt = rr_ptr;
      grant_nxt  = grant_q;
      s0_tready  = 1'b0;
      s1_tready  = 1'b0;
      accept     = 1'b0;
      acc_last   = 1'b0;
      acc_data   = s0_tdata;
      case (state)
         IDLE: begin
            if (s0_tvalid | s1_tvalid) begin
               grant_nxt = (s0_tvalid & s1_tvalid) ? rr_ptr : s1_tvalid;
               state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            if (grant_q) begin
               s1_tready = (credits != '0);
               accept    = s1_tvalid & s1_tready;
               acc_last  = s1_tlast;
               acc_data  = s1_tdata;
            end else begin
               s0_tready = (credits != '0);
               accept    = s0_tvalid & s0_tready;
               acc_last  = s0_tlast;
               acc_data  = s0_tdata;
            end
            if (accept & acc_last) begin
               state_nxt  = IDLE;
               rr_ptr_nxt = ~grant_q;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A return at full credit is a protocol error and is dropped so the count saturates.
   always_ff @(posedge m_axi_mm2s_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         credits <= CRED_MAX;
      end else begin
         case ({accept, fifo_rd_en})
            2'b10:   credits <= credits - CRED_ONE;
            2'b01:   if (credits != CRED_MAX) credits <= credits + CRED_ONE;
            default: credits <= credits;
         endcase
      end
   end

   always_ff @(posedge m_axi_mm2s_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         aes_din  <= '0;
         tag_vld  <= '0;
         tag_last <= '0;
         tag_ch   <= '0;
      end else begin
         if (accept) aes_din <= acc_data;
         tag_vld  <= {tag_vld[C_PIPE_LAT-1:0],  accept};
         tag_last <= {tag_last[C_PIPE_LAT-1:0], acc_last & accept};
         tag_ch   <= {tag_ch[C_PIPE_LAT-1:0],   grant_q & accept};
      end
   end

   assign aes_din_vld = tag_vld[0];
   assign grant_ch    = grant_q;
   assign fifo_wr_en  = tag_vld[C_PIPE_LAT];
   assign fifo_din    = fifo_wr_en ? {tag_ch[C_PIPE_LAT], tag_last[C_PIPE_LAT], aes_dout} : '0;
   assign pkt_done    = {fifo_wr_en & tag_last[C_PIPE_LAT] &  tag_ch[C_PIPE_LAT],
                         fifo_wr_en & tag_last[C_PIPE_LAT] & ~tag_ch[C_PIPE_LAT]};
   assign busy        = (state == ACTIVE) | (|tag_vld);

endmodule

// File: tb/tb_aes_stream_sched.sv
// Bench for aes_stream_sched: a simple AES stand-in, random-data sources and a scoreboard of
// accepted beats due at the FIFO exactly 1+LAT cycles later, plus directed scheduling checks.
module tb_aes_stream_sched;

   localparam int DW    = 128;
   localparam int LAT   = 30;
   localparam int DEPTH = 16;
   localparam int CW    = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [DW-1:0]   s0_tdata, s1_tdata;
   logic            s0_tvalid, s0_tlast, s0_tready;
   logic            s1_tvalid, s1_tlast, s1_tready;
   logic [DW-1:0]   aes_din, aes_dout;
   logic            aes_din_vld;
   logic            fifo_wr_en;
   logic [DW+1:0]   fifo_din;
   logic            fifo_rd_en;
   logic            grant_ch, busy;
   logic [1:0]      pkt_done;

   always #5 clk = ~clk;

   aes_stream_sched #(
      .C_DATA_WIDTH (DW),
      .C_PIPE_LAT   (LAT),
      .C_FIFO_DEPTH (DEPTH),
      .C_CRED_WIDTH (CW)
   ) dut (
      .m_axi_mm2s_aclk (clk),
      .axi_resetn      (rst_n),
      .s0_tdata        (s0_tdata),
      .s0_tvalid       (s0_tvalid),
      .s0_tlast        (s0_tlast),
      .s0_tready       (s0_tready),
      .s1_tdata        (s1_tdata),
      .s1_tvalid       (s1_tvalid),
      .s1_tlast        (s1_tlast),
      .s1_tready       (s1_tready),
      .aes_din         (aes_din),
      .aes_din_vld     (aes_din_vld),
      .aes_dout        (aes_dout),
      .fifo_wr_en      (fifo_wr_en),
      .fifo_din        (fifo_din),
      .fifo_rd_en      (fifo_rd_en),
      .grant_ch        (grant_ch),
      .busy            (busy),
      .pkt_done        (pkt_done)
   );

   // Stand-in for the AES core: a fixed keyless mixing function behind LAT register stages.
   function automatic logic [DW-1:0] aes_f(input logic [DW-1:0] x);
      return {x[63:0], x[127:64]} ^ 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
   endfunction

   logic [DW-1:0] aes_pipe [LAT];
   always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) aes_pipe[i] <= aes_pipe[i-1];
      aes_pipe[0] <= aes_f(aes_din);
   end
   assign aes_dout = aes_pipe[LAT-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int due; logic [DW+1:0] din; } exp_t;
   typedef struct { int cyc; logic ch; } acc_t;

   exp_t          q[$];
   acc_t          acc_log[$];
   int            wr_log[$];
   int            rem [2];
   logic [DW-1:0] cur [2];
   bit            tog [2];
   bit            phase;
   bit            auto_pop, force_rd;
   int            fifo_occ, cred_m;
   int            tests = 0;
   int            fails = 0;

   task automatic chk(input string tag, input logic [DW+1:0] obs, input logic [DW+1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_s0_tready"}, s0_tready, 0);
      chk({tag, "_s1_tready"}, s1_tready, 0);
      chk({tag, "_aes_din"}, aes_din, 0);
      chk({tag, "_aes_din_vld"}, aes_din_vld, 0);
      chk({tag, "_fifo_wr_en"}, fifo_wr_en, 0);
      chk({tag, "_fifo_din"}, fifo_din, 0);
      chk({tag, "_grant_ch"}, grant_ch, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_pkt_done"}, pkt_done, 0);
   endtask

   task automatic take(input int c, input logic last, input logic [DW-1:0] data);
      exp_t e;
      acc_t a;
      e.due = cyc + 1 + LAT;
      e.din = {c[0], last, aes_f(data)};
      q.push_back(e);
      a.cyc = cyc;
      a.ch  = c[0];
      acc_log.push_back(a);
      rem[c]--;
      cur[c] = rnd128();
   endtask

   // One clock cycle: called and returns at posedge+1, samples at the negedge.
   task automatic tick();
      logic a0, a1, exp_wr;
      logic [1:0] exp_done;
      phase      = ~phase;
      s0_tvalid  = (rem[0] > 0) && (!tog[0] || phase);
      s0_tdata   = cur[0];
      s0_tlast   = (rem[0] == 1);
      s1_tvalid  = (rem[1] > 0) && (!tog[1] || phase);
      s1_tdata   = cur[1];
      s1_tlast   = (rem[1] == 1);
      fifo_rd_en = force_rd || (auto_pop && fifo_occ > 0);
      force_rd   = 1'b0;
      @(negedge clk);
      a0 = s0_tvalid & s0_tready;
      a1 = s1_tvalid & s1_tready;
      chk("tready_onehot", s0_tready & s1_tready, 0);
      if (cred_m == 0) chk("tready_no_credit", s0_tready | s1_tready, 0);
      if (q.size() > 0) chk("busy_in_flight", busy, 1);
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      exp_wr   = (q.size() > 0) && (q[0].due == cyc);
      exp_done = 2'b00;
      if (exp_wr && q[0].din[DW]) exp_done[q[0].din[DW+1]] = 1'b1;
      if (exp_wr || fifo_wr_en || pkt_done != 2'b00) begin
         chk("fifo_wr_en", fifo_wr_en, exp_wr);
         chk("pkt_done", pkt_done, exp_done);
         if (exp_wr) begin
            chk("fifo_din", fifo_din, q[0].din);
            void'(q.pop_front());
         end
      end
      if (fifo_wr_en) wr_log.push_back(cyc);
      if (a0) take(0, s0_tlast, s0_tdata);
      if (a1) take(1, s1_tlast, s1_tdata);
      if ((a0 | a1) && !fifo_rd_en) cred_m--;
      else if (!(a0 | a1) && fifo_rd_en && cred_m < DEPTH) cred_m++;
      fifo_occ = fifo_occ + int'(fifo_wr_en) - int'(fifo_rd_en);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag, input int max);
      int  n = 0;
      bit  done;
      done = 1'b0;
      while (!done && n < max) begin
         done = (rem[0] == 0) && (rem[1] == 0) && (q.size() == 0) && !busy && (fifo_occ == 0);
         if (!done) begin
            tick();
            n++;
         end
      end
      chk({tag, "_drain_timeout"}, done, 1);
   endtask

   initial begin
      rst_n = 1'b1;
      s0_tvalid = 0; s0_tlast = 0; s0_tdata = '0;
      s1_tvalid = 0; s1_tlast = 0; s1_tdata = '0;
      fifo_rd_en = 0;
      rem[0] = 0; rem[1] = 0; tog[0] = 0; tog[1] = 0;
      cur[0] = rnd128(); cur[1] = rnd128();
      phase = 0; auto_pop = 1; force_rd = 0;
      fifo_occ = 0; cred_m = DEPTH;
      #1 rst_n = 1'b0;
      #2 chk_all_zero("reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Contention with rr_ptr=0: ch0 packet, one bubble, ch1 packet, then ch0 wins again.
      acc_log.delete();
      rem[0] = 3; rem[1] = 2;
      drain("rr", 200);
      chk("rr_count", acc_log.size(), 5);
      if (acc_log.size() == 5) begin
         for (int i = 0; i < 5; i++) chk("rr_order", acc_log[i].ch, (i < 3) ? 0 : 1);
         chk("rr_bubble", acc_log[3].cyc - acc_log[2].cyc, 2);
      end
      acc_log.delete();
      rem[0] = 1; rem[1] = 1;
      drain("rr2", 200);
      chk("rr2_count", acc_log.size(), 2);
      if (acc_log.size() == 2) begin
         chk("rr2_first", acc_log[0].ch, 0);
         chk("rr2_second", acc_log[1].ch, 1);
      end

      // Single 4-beat ch0 packet: writes on cycles 31..34 after the first accept.
      acc_log.delete(); wr_log.delete();
      rem[0] = 4;
      drain("single", 200);
      chk("single_wr_count", wr_log.size(), 4);
      if (wr_log.size() == 4 && acc_log.size() == 4) begin
         chk("single_latency", wr_log[0] - acc_log[0].cyc, 1 + LAT);
         chk("single_burst", wr_log[3] - wr_log[0], 3);
      end

      // Credit exhaustion with no pops, one pulse, then accept+return at credits=1.
      acc_log.delete();
      auto_pop = 0;
      rem[1] = 20;
      repeat (60) tick();
      chk("credit_accepts", acc_log.size(), DEPTH);
      chk("credit_tready_low", s1_tready, 0);
      force_rd = 1;
      repeat (10) tick();
      chk("credit_one_more", acc_log.size(), DEPTH + 1);
      force_rd = 1;
      tick();
      force_rd = 1;
      tick();
      chk("cred1_accept", acc_log.size(), DEPTH + 2);
      chk("cred1_tready_held", s1_tready, 1);
      tick();
      chk("cred1_accept2", acc_log.size(), DEPTH + 3);
      chk("cred1_tready_low", s1_tready, 0);
      auto_pop = 1;
      drain("credit", 400);

      // Reset mid-packet with beats in flight.
      rem[0] = 20;
      for (int n = 0; n < 40 && q.size() < 10; n++) tick();
      chk("rst_inflight", q.size() >= 10, 1);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("midrst");
      q.delete();
      rem[0] = 0; rem[1] = 0;
      s0_tvalid = 0; s1_tvalid = 0; fifo_rd_en = 0;
      cred_m = DEPTH; fifo_occ = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      wr_log.delete();
      repeat (40) tick();
      chk("rst_no_wr", wr_log.size(), 0);
      acc_log.delete();
      auto_pop = 0;
      rem[1] = DEPTH + 1;
      repeat (45) tick();
      chk("rst_credits", acc_log.size(), DEPTH);
      auto_pop = 1;
      drain("rst", 400);

      // ch1 tvalid toggling 1010 across a 6-beat packet.
      acc_log.delete();
      tog[1] = 1;
      rem[1] = 6;
      drain("toggle", 300);
      chk("toggle_count", acc_log.size(), 6);
      tog[1] = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
